// File: rtl/sys1_input_cond_if.sv
// sys1_input_cond_if: HPS-side inputs and core-facing active-low outputs of the input conditioner
interface sys1_input_cond_if;
  logic [7:0]  sysmode;
  logic [15:0] joy;
  logic [24:0] mouse;
  logic        vs;
  logic [7:0]  inp0;
  logic [7:0]  inp1;
  logic [7:0]  inp2;
  logic        pause_req;
  modport master (output sysmode, joy, mouse, vs, input inp0, inp1, inp2, pause_req);
  modport slave (input sysmode, joy, mouse, vs, output inp0, inp1, inp2, pause_req);
endinterface

// File: rtl/sys1_input_cond.sv
// sys1_input_cond: maps joystick/mouse to SEGA System 1 INP0-2 with coin stretch, pause toggle and spinner
module sys1_input_cond #(
  parameter int COIN_FRAMES = 3,
  parameter int SPIN_SLOW   = 2,
  parameter int SPIN_FAST   = 6
) (
  input logic clk,
  input logic reset,
  sys1_input_cond_if.slave bus
);
  logic       vs_d, coin_d, pause_d, pause_rise, mouse_d24;
  logic       tick, coin, t, spin, water;
  logic [3:0] cnt, cnt_nxt;
  logic [7:0] pos, step, dig, mdx, map0, map2;
  logic [15:0] j;
  logic unused_bits;
  assign unused_bits = ^{bus.sysmode[7:6], bus.sysmode[4], bus.sysmode[2:0], bus.joy[15:13], bus.mouse[23:16], bus.mouse[7:3]};
  // Edge detects, coin next-count, spinner delta and per-mode output mapping
  always_comb begin
    j       = bus.joy;
    tick    = bus.vs & ~vs_d;
    spin    = bus.sysmode[5];
    water   = bus.sysmode[3];
    cnt_nxt = (j[11] && !coin_d && cnt == 4'd0) ? 4'(COIN_FRAMES) :
              (tick && cnt != 4'd0) ? cnt - 4'd1 : cnt;
    coin    = cnt_nxt != 4'd0;
    step    = j[5] ? 8'(SPIN_FAST) : 8'(SPIN_SLOW);
    dig     = !tick ? 8'd0 : (j[0] && !j[1]) ? step : (j[1] && !j[0]) ? -step : 8'd0;
    mdx     = (bus.mouse[24] != mouse_d24) ? bus.mouse[15:8] : 8'd0;
    t       = j[4] | (|bus.mouse[2:0]);
    map0    = spin ? pos :
              water ? {j[1], j[0], j[3], j[2], j[5], j[4], j[7], j[6]} :
                      {j[1], j[0], j[3], j[2], 1'b0, j[5], j[4], j[6]};
    map2    = spin ? {t, t, j[10], j[9], 3'b000, coin} :
              water ? {j[8], j[8], j[10], j[9], 3'b000, coin} :
                      {2'b00, j[10], j[9], 3'b000, coin};
  end
  // Edge-detect history, coin counter, pause toggle and wrapping spinner position
  always_ff @(posedge clk) begin
    if (reset) begin
      vs_d       <= 1'b0;
      coin_d     <= 1'b0;
      pause_d    <= 1'b0;
      pause_rise <= 1'b0;
      mouse_d24  <= 1'b0;
      cnt        <= 4'd0;
      pos        <= 8'd0;
      bus.pause_req <= 1'b0;
    end else begin
      vs_d       <= bus.vs;
      coin_d     <= j[11];
      pause_d    <= j[12];
      pause_rise <= j[12] & ~pause_d;
      mouse_d24  <= bus.mouse[24];
      cnt        <= cnt_nxt;
      pos        <= pos + dig + mdx;
      bus.pause_req <= bus.pause_req ^ pause_rise;
    end
  end
  // Registered active-low outputs to the core
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.inp0 <= 8'hFF;
      bus.inp1 <= 8'hFF;
      bus.inp2 <= 8'hFF;
    end else begin
      bus.inp0 <= ~map0;
      bus.inp1 <= ~map0;
      bus.inp2 <= ~map2;
    end
  end
endmodule
